// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, exception/interrupt request
// generation, the mfc0 read mux and the EPC feed for eret.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL = 32'h4D495053,
    parameter logic [5:0]  IM_RESET = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        mtc0op,
    input  logic        eretop,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    output logic        exc_req,
    output logic [31:0] epc_out,
    output logic [31:0] rd_data
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        unused_pc_low;

    assign unused_pc_low = ^pc_m[1:0];

    assign int_pend = (|(hw_int & im)) & ie & ~exl;
    assign exc_pend = (exc_code_in != 5'd0) & ~exl;
    // Registers already read as their reset values during reset, so gate explicitly.
    assign exc_req  = reset & (int_pend | exc_pend);

    assign pc_aligned = {pc_m[31:2], 2'b00};
    assign epc_next   = bd_m ? (pc_aligned - 32'd4) : pc_aligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= IM_RESET;
            exl      <= 1'b0;
            ie       <= 1'b1;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= hw_int;
            if (exc_req) begin
                exl      <= 1'b1;
                exc_code <= int_pend ? 5'd0 : exc_code_in;
                bd       <= bd_m;
                epc      <= epc_next;
            end else begin
                if (mtc0op) begin
                    case (wr_addr)
                        5'd12: begin
                            im  <= wr_data[15:10];
                            exl <= wr_data[1];
                            ie  <= wr_data[0];
                        end
                        5'd14:   epc <= {wr_data[31:2], 2'b00};
                        default: ;
                    endcase
                end
                // Placed after the mtc0 write so eret owns EXL if both are set.
                if (eretop)
                    exl <= 1'b0;
            end
        end
    end

    assign sr_val    = {16'd0, im, 8'd0, exl, ie};
    assign cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
    assign epc_out   = epc;

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            5'd12:   rd_data = sr_val;
            5'd13:   rd_data = cause_val;
            5'd14:   rd_data = epc;
            5'd15:   rd_data = PRID_VAL;
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: hand-computed expectations for reset, interrupts,
// exceptions, EXL gating, mtc0/eret and the read mux.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mtc0op;
    logic        eretop;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exc_req;
    logic [31:0] epc_out;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mtc0op      (mtc0op),
        .eretop      (eretop),
        .pc_m        (pc_m),
        .bd_m        (bd_m),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .exc_req     (exc_req),
        .epc_out     (epc_out),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0;
        mtc0op = 1'b0; eretop = 1'b0; pc_m = 32'd0; bd_m = 1'b0;
        exc_code_in = 5'd0; hw_int = 6'd0;
        #12;
        rd(5'd12, 32'h0000FC01, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        chk("rst_req", {31'd0, exc_req}, 32'd0);
        tick();
        reset = 1'b1;
        #1;

        // Interrupt on hw_int[2]
        hw_int = 6'b000100; pc_m = 32'h3008; bd_m = 1'b0;
        #1;
        chk("int_req", {31'd0, exc_req}, 32'd1);
        tick();
        chk("int_epc", epc_out, 32'h3008);
        rd(5'd13, 32'h00001000, "int_cause");
        rd(5'd12, 32'h0000FC03, "int_sr_exl");
        chk("int_exl_gate", {31'd0, exc_req}, 32'd0);

        // mtc0 EPC while EXL=1, then asynchronous reset mid-cycle
        mtc0op = 1'b1; wr_addr = 5'd14; wr_data = 32'h00003011;
        tick();
        mtc0op = 1'b0;
        chk("mtc0_epc_align", epc_out, 32'h3010);
        #2;
        reset = 1'b0;
        #1;
        rd(5'd12, 32'h0000FC01, "mid_rst_sr");
        rd(5'd13, 32'h0, "mid_rst_cause");
        rd(5'd14, 32'h0, "mid_rst_epc");
        chk("mid_rst_req", {31'd0, exc_req}, 32'd0);
        hw_int = 6'd0;
        tick();
        reset = 1'b1;
        #1;

        // Exception in a delay slot, followed by a masked second exception
        exc_code_in = 5'd12; bd_m = 1'b1; pc_m = 32'h3020;
        #1;
        chk("exc_req", {31'd0, exc_req}, 32'd1);
        tick();
        exc_code_in = 5'd4; bd_m = 1'b0;
        #1;
        chk("exc_epc", epc_out, 32'h301C);
        rd(5'd13, 32'h80000030, "exc_cause");
        chk("exc_exl_gate", {31'd0, exc_req}, 32'd0);
        tick();
        chk("exc_epc_held", epc_out, 32'h301C);
        exc_code_in = 5'd0;
        eretop = 1'b1;
        tick();
        eretop = 1'b0;
        rd(5'd12, 32'h0000FC01, "eret_sr");

        // mtc0 SR: only IM[0] and IE
        mtc0op = 1'b1; wr_addr = 5'd12; wr_data = 32'h00000401;
        tick();
        mtc0op = 1'b0;
        rd(5'd12, 32'h00000401, "mtc0_sr");
        hw_int = 6'b000001;
        #1;
        chk("im0_req", {31'd0, exc_req}, 32'd1);
        hw_int = 6'b000010;
        #1;
        chk("im1_masked", {31'd0, exc_req}, 32'd0);

        // Interrupt beats exception; concurrent mtc0 EPC squashed
        hw_int = 6'b000001; exc_code_in = 5'd4; pc_m = 32'h3040; bd_m = 1'b0;
        mtc0op = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD0000;
        #1;
        chk("prio_req", {31'd0, exc_req}, 32'd1);
        tick();
        mtc0op = 1'b0; exc_code_in = 5'd0;
        chk("prio_epc", epc_out, 32'h3040);
        rd(5'd13, 32'h00000400, "prio_cause");
        chk("prio_exl_gate", {31'd0, exc_req}, 32'd0);

        // eret with interrupt still pending: taken right after EXL clears
        eretop = 1'b1;
        tick();
        eretop = 1'b0;
        rd(5'd12, 32'h00000401, "eret2_sr");
        chk("eret2_req", {31'd0, exc_req}, 32'd1);
        rd(5'd15, 32'h4D495053, "prid");
        rd(5'd7, 32'h0, "rd_other");
        hw_int = 6'd0;
        #1;
        chk("idle_req", {31'd0, exc_req}, 32'd0);

        // Cause is read-only to mtc0
        mtc0op = 1'b1; wr_addr = 5'd13; wr_data = 32'hFFFFFFFF;
        tick();
        mtc0op = 1'b0;
        rd(5'd13, 32'h0, "cause_ro");

        // Delay-slot EPC wrap at pc_m=0
        exc_code_in = 5'd8; bd_m = 1'b1; pc_m = 32'h0;
        tick();
        exc_code_in = 5'd0; bd_m = 1'b0;
        chk("wrap_epc", epc_out, 32'hFFFFFFFC);
        rd(5'd13, 32'h80000020, "wrap_cause");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
